// File: rtl/y86_pkg.sv
// Shared Y86-64 decode constants: instruction codes, default widths, and the "no register" id.
package y86_pkg;
  localparam int DATA_W_DEF = 64;
  localparam int RID_W_DEF  = 4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [RID_W_DEF-1:0] RNONE = '1;
endpackage

// File: rtl/y86_regfile.sv
// Register file: two write ports (load port wins on a shared id), two asynchronous read ports.
module y86_regfile #(
  parameter int DATA_W = 64,
  parameter int NREGS  = 15,
  parameter int RID_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RID_W-1:0]  wr_e_id,
  input  logic [DATA_W-1:0] wr_e_val,
  input  logic [RID_W-1:0]  wr_m_id,
  input  logic [DATA_W-1:0] wr_m_val,
  input  logic [RID_W-1:0]  rd_a_id,
  output logic [DATA_W-1:0] rd_a_val,
  input  logic [RID_W-1:0]  rd_b_id,
  output logic [DATA_W-1:0] rd_b_val
);
  logic [NREGS-1:0][DATA_W-1:0] regs;

  // Ids at or above NREGS (including RNONE) never match an entry, so they never write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_m_id == RID_W'(i))      regs[i] <= wr_m_val;
        else if (wr_e_id == RID_W'(i)) regs[i] <= wr_e_val;
      end
    end
  end

  assign rd_a_val = (rd_a_id < RID_W'(NREGS)) ? regs[rd_a_id] : '0;
  assign rd_b_val = (rd_b_id < RID_W'(NREGS)) ? regs[rd_b_id] : '0;
endmodule

// File: rtl/y86_decode_fwd.sv
// Y86-64 decode stage: source/dest selection, five-source forwarding, load-use stall, D->E register.
module y86_decode_fwd
  import y86_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = 15,
  parameter int RID_W  = RID_W_DEF,
  parameter int RSP_ID = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d_valid,
  input  logic [3:0]        d_icode,
  input  logic [3:0]        d_ifun,
  input  logic [RID_W-1:0]  d_rA,
  input  logic [RID_W-1:0]  d_rB,
  input  logic [DATA_W-1:0] d_valC,
  input  logic [DATA_W-1:0] d_valP,
  input  logic [RID_W-1:0]  e_dstE,
  input  logic [DATA_W-1:0] e_valE,
  input  logic [RID_W-1:0]  m_dstM,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [RID_W-1:0]  M_dstE,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [RID_W-1:0]  W_dstM,
  input  logic [DATA_W-1:0] W_valM,
  input  logic [RID_W-1:0]  W_dstE,
  input  logic [DATA_W-1:0] W_valE,
  input  logic              e_bubble_req,
  output logic              d_stall,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [DATA_W-1:0] E_valC,
  output logic [DATA_W-1:0] E_valA,
  output logic [DATA_W-1:0] E_valB,
  output logic [RID_W-1:0]  E_dstE,
  output logic [RID_W-1:0]  E_dstM,
  output logic [RID_W-1:0]  E_srcA,
  output logic [RID_W-1:0]  E_srcB
);
  localparam logic [RID_W-1:0] RN  = '1;
  localparam logic [RID_W-1:0] RSP = RID_W'(RSP_ID);

  logic [RID_W-1:0]  src_a, src_b, dst_e, dst_m;
  logic [DATA_W-1:0] rf_a, rf_b, val_a, val_b;
  logic              bubble;

  always_comb begin
    src_a = RN;
    src_b = RN;
    dst_e = RN;
    dst_m = RN;
    case (d_icode)
      I_RRMOVQ: begin src_a = d_rA; dst_e = d_rB; end
      I_IRMOVQ: dst_e = d_rB;
      I_RMMOVQ: begin src_a = d_rA; src_b = d_rB; end
      I_MRMOVQ: begin src_b = d_rB; dst_m = d_rA; end
      I_OPQ:    begin src_a = d_rA; src_b = d_rB; dst_e = d_rB; end
      I_CALL:   begin src_b = RSP; dst_e = RSP; end
      I_RET:    begin src_a = RSP; src_b = RSP; dst_e = RSP; end
      I_PUSHQ:  begin src_a = d_rA; src_b = RSP; dst_e = RSP; end
      I_POPQ:   begin src_a = RSP; src_b = RSP; dst_e = RSP; dst_m = d_rA; end
      default: ;
    endcase
  end

  y86_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .RID_W(RID_W)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_e_id  (W_dstE),
    .wr_e_val (W_valE),
    .wr_m_id  (W_dstM),
    .wr_m_val (W_valM),
    .rd_a_id  (src_a),
    .rd_a_val (rf_a),
    .rd_b_id  (src_b),
    .rd_b_val (rf_b)
  );

  // Youngest producer wins; a stage with dst RNONE never forwards.
  always_comb begin
    val_a = rf_a;
    if (d_icode == I_CALL || d_icode == I_JXX)  val_a = d_valP;
    else if (e_dstE != RN && e_dstE == src_a)   val_a = e_valE;
    else if (m_dstM != RN && m_dstM == src_a)   val_a = m_valM;
    else if (M_dstE != RN && M_dstE == src_a)   val_a = M_valE;
    else if (W_dstM != RN && W_dstM == src_a)   val_a = W_valM;
    else if (W_dstE != RN && W_dstE == src_a)   val_a = W_valE;
  end

  always_comb begin
    val_b = rf_b;
    if (e_dstE != RN && e_dstE == src_b)        val_b = e_valE;
    else if (m_dstM != RN && m_dstM == src_b)   val_b = m_valM;
    else if (M_dstE != RN && M_dstE == src_b)   val_b = M_valE;
    else if (W_dstM != RN && W_dstM == src_b)   val_b = W_valM;
    else if (W_dstE != RN && W_dstE == src_b)   val_b = W_valE;
  end

  assign d_stall = d_valid && (E_icode == I_MRMOVQ || E_icode == I_POPQ) &&
                   E_dstM != RN && (E_dstM == src_a || E_dstM == src_b);
  assign bubble  = d_stall || e_bubble_req || !d_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bubble) begin
      E_icode <= I_NOP;
      E_ifun  <= '0;
      E_valC  <= '0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_dstE  <= RN;
      E_dstM  <= RN;
      E_srcA  <= RN;
      E_srcB  <= RN;
    end else begin
      E_icode <= d_icode;
      E_ifun  <= d_ifun;
      E_valC  <= d_valC;
      E_valA  <= val_a;
      E_valB  <= val_b;
      E_dstE  <= dst_e;
      E_dstM  <= dst_m;
      E_srcA  <= src_a;
      E_srcB  <= src_b;
    end
  end
endmodule

// File: doc/y86_decode_fwd.md
Name: y86_decode_fwd

Overview:
- Parametrised Y86-64 pipeline decode stage: register file, source/destination selection, five-source data forwarding, load-use hazard detection, and the D->E pipeline register with stall/bubble control.
- Sits between fetch (D register outputs) and execute.
- Generalises the fixed 64-bit, 15-register decode with configurable width and register count, an explicit hazard/stall output, and bubble injection.

Parameters:
- DATA_W, 64, datapath width of register values, valC and valP.
- NREGS, 15, architectural registers; ids 0..NREGS-1 are valid.
- RID_W, 4, register-id width; id all-ones = RNONE; NREGS < 2^RID_W.
- RSP_ID, 4, stack-pointer register id.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- d_valid  in  1  D register holds a real instruction; 0 = treat as nop.
- d_icode  in  4  instruction code.
- d_ifun  in  4  function code.
- d_rA, d_rB  in  RID_W  register specifiers.
- d_valC, d_valP  in  DATA_W  constant and next PC.
- e_dstE  in  RID_W, e_valE  in  DATA_W  execute-stage ALU result.
- m_dstM  in  RID_W, m_valM  in  DATA_W  memory-stage load data.
- M_dstE  in  RID_W, M_valE  in  DATA_W  M-register ALU result.
- W_dstM  in  RID_W, W_valM  in  DATA_W  writeback load data; also a regfile write port.
- W_dstE  in  RID_W, W_valE  in  DATA_W  writeback ALU result; also a regfile write port.
- e_bubble_req  in  1  external bubble request (mispredict/ret); forces E to nop.
- d_stall  out  1  load-use hazard; fetch must hold F and D.
- E_icode, E_ifun  out  4  E register.
- E_valC, E_valA, E_valB  out  DATA_W  E register.
- E_dstE, E_dstM, E_srcA, E_srcB  out  RID_W  E register.

Behaviour:
- Reset (async, rst_n=0): all regfile entries 0; E_icode=1 (nop), E_ifun=0, E_val* = 0, all E_ ids = RNONE, d_stall=0. Release is synchronous to clk.
- Source selection (combinational):
  - srcA = rA for rrmovq(2), rmmovq(4), opq(6), pushq(A); RSP_ID for popq(B), ret(9); else RNONE.
  - srcB = rB for opq, rmmovq, mrmovq(5); RSP_ID for pushq, popq, call(8), ret; else RNONE.
- Destination selection:
  - dstE = rB for rrmovq, irmovq(3), opq; RSP_ID for pushq, popq, call, ret; else RNONE.
  - dstM = rA for mrmovq, popq; else RNONE.
- valA:
  - call or jxx(7): valA = valP.
  - Otherwise priority forwarding on srcA: e_dstE, m_dstM, M_dstE, W_dstM, W_dstE, then regfile.
  - A source matches only when its dst ≠ RNONE.
- valB: same priority chain on srcB, with no valP case.
- Regfile: two write ports at posedge. W_dstE writes W_valE and W_dstM writes W_valM. If both target the same id, W_valM wins. RNONE and ids ≥ NREGS are not written.
- Load-use: d_stall = 1 when E_icode ∈ {mrmovq, popq} and E_dstM ∈ {srcA, srcB} with E_dstM ≠ RNONE. Gated by d_valid.
- E register update each posedge:
  - If d_stall or e_bubble_req or !d_valid: load bubble (nop, ids RNONE, values 0).
  - Else: load decoded fields.
  - Simultaneous stall and bubble request: bubble. D-hold remains fetch's job via d_stall.
- Latency: 1 cycle from D inputs to E outputs.
- Widths: all values pass unmodified; no arithmetic in this block.

Decomposition:
- Shared package y86_pkg: icode constants (HALT..POPQ), RNONE, default DATA_W/RID_W.
- One sub-module y86_regfile: NREGS x DATA_W, 2 write ports, 2 async read ports, async active-low reset.
- Forwarding mux and hazard logic stay in the top.

Test Plan:
- Reset mid-run: assert rst_n=0 while E holds opq -> E_icode=1, E_dstE=F, d_stall=0 immediately, with no clock edge needed.
- Regfile path: write W_dstE=2, W_valE=0x1234; next cycle decode rrmovq rA=2 rB=3 -> E_valA=0x1234, E_dstE=3.
- Forward priority: e_dstE=5 with 0xAA, M_dstE=5 with 0xBB, W_dstE=5 with 0xCC; decode opq rA=5 -> E_valA=0xAA. Drop e_dstE to F -> 0xBB.
- Load-use: E holds mrmovq dstM=7; decode opq rA=7 -> d_stall=1, next E is nop. Following cycle with m_dstM=7, m_valM=0x55 -> E_valA=0x55, d_stall=0.
- Call/RSP: decode call valP=0x40, regfile RSP=0x100 -> E_valA=0x40, E_valB=0x100, E_dstE=4, E_srcB=4.
- Same-id writeback: W_dstE=W_dstM=6 with 0x11/0x22 -> reg 6 reads 0x22. e_bubble_req=1 with a valid instruction -> E nop.
